// File: rtl/wb_ep_txfifo_pkg.sv
// Shared register map, bit positions and FSM state type for the
// Wishbone-to-EP-buffer TX staging FIFO.
package wb_ep_txfifo_pkg;
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;

   localparam int CTRL_START_BIT  = 31;
   localparam int CTRL_IRQ_EN_BIT = 30;
   localparam int STAT_BUSY_BIT   = 8;
   localparam int STAT_DONE_BIT   = 9;
   localparam int STAT_OVF_BIT    = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_COPY = 1'b1
   } state_t;
endpackage

// File: rtl/wb_ep_txfifo_fifo_sync.sv
// Single-clock FIFO with show-ahead read data; a push while full is only
// accepted when a pop frees a slot in the same cycle.
module fifo_sync #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int LW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_ena,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ena,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (level_reg == FULL_LEVEL);
   assign empty   = (level_reg == '0);
   assign level   = level_reg;
   assign rd_ok   = rd_ena & ~empty;
   assign wr_ok   = wr_ena & (~full | rd_ok);
   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end
endmodule

// File: rtl/wb_ep_txfifo.sv
// Wishbone slave staging words in a FIFO and copying a programmed count of
// them into the USB EP TX buffer, with a completion interrupt.
module wb_ep_txfifo
   import wb_ep_txfifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LW    = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  wb_addr,
   input  logic [31:0] wb_wdata,
   output logic [31:0] wb_rdata,
   input  logic        wb_we,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   output logic        wb_ack,
   output logic [8:0]  ep_tx_addr,
   output logic [31:0] ep_tx_data,
   output logic        ep_tx_we,
   output logic        irq
);
   state_t         state_reg, state_next;
   logic           wb_ack_reg;
   logic [31:0]    wb_rdata_reg;
   logic [8:0]     base_reg;
   logic [LW-1:0]  len_reg;
   logic           irq_en_reg;
   logic           done_reg;
   logic           ovf_reg;
   logic           last_reg;
   logic [8:0]     ptr_reg;
   logic [LW-1:0]  remaining_reg;
   logic [8:0]     ep_tx_addr_reg;
   logic [31:0]    ep_tx_data_reg;
   logic           ep_tx_we_reg;

   logic           req, wr_req, push, ctrl_wr, status_wr, start_cmd;
   logic           pop, start_run, start_empty, last_pop;
   logic [LW-1:0]  len_wr;
   logic [31:0]    rd_mux;
   logic [31:0]    fifo_rd_data;
   logic           fifo_full, fifo_empty;
   logic [LW-1:0]  fifo_level;

   assign req       = wb_cyc & wb_stb & ~wb_ack_reg;
   assign wr_req    = req & wb_we;
   assign push      = wr_req & (wb_addr == REG_DATA);
   assign ctrl_wr   = wr_req & (wb_addr == REG_CTRL);
   assign status_wr = wr_req & (wb_addr == REG_STATUS);
   assign start_cmd = ctrl_wr & wb_wdata[CTRL_START_BIT];
   assign len_wr    = wb_wdata[LW+15:16];

   fifo_sync #(.WIDTH(32), .DEPTH(DEPTH), .LW(LW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_ena  (push),
      .wr_data (wb_wdata),
      .rd_ena  (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pop         = 1'b0;
      start_run   = 1'b0;
      start_empty = 1'b0;
      last_pop    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start_cmd) begin
               if (len_wr != '0) begin
                  start_run  = 1'b1;
                  state_next = ST_COPY;
               end else begin
                  start_empty = 1'b1;
               end
            end
         end
         ST_COPY: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (remaining_reg == LW'(1)) begin
                  last_pop   = 1'b1;
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (wb_addr)
         REG_CTRL: begin
            rd_mux[8:0]             = base_reg;
            rd_mux[LW+15:16]        = len_reg;
            rd_mux[CTRL_IRQ_EN_BIT] = irq_en_reg;
         end
         REG_STATUS: begin
            rd_mux[LW-1:0]        = fifo_level;
            rd_mux[STAT_BUSY_BIT] = (state_reg == ST_COPY);
            rd_mux[STAT_DONE_BIT] = done_reg;
            rd_mux[STAT_OVF_BIT]  = ovf_reg;
         end
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_ack_reg     <= 1'b0;
         wb_rdata_reg   <= '0;
         base_reg       <= '0;
         len_reg        <= '0;
         irq_en_reg     <= 1'b0;
         done_reg       <= 1'b0;
         ovf_reg        <= 1'b0;
         last_reg       <= 1'b0;
         ptr_reg        <= '0;
         remaining_reg  <= '0;
         ep_tx_addr_reg <= '0;
         ep_tx_data_reg <= '0;
         ep_tx_we_reg   <= 1'b0;
      end else begin
         wb_ack_reg   <= req;
         wb_rdata_reg <= (req && !wb_we) ? rd_mux : '0;
         // Fields are staged even mid-copy so the next run picks them up.
         if (ctrl_wr) begin
            base_reg   <= wb_wdata[8:0];
            len_reg    <= len_wr;
            irq_en_reg <= wb_wdata[CTRL_IRQ_EN_BIT];
         end
         if (start_run) begin
            ptr_reg       <= wb_wdata[8:0];
            remaining_reg <= len_wr;
         end else if (pop) begin
            ptr_reg       <= ptr_reg + 9'd1;
            remaining_reg <= remaining_reg - LW'(1);
         end
         ep_tx_we_reg <= pop;
         if (pop) begin
            ep_tx_addr_reg <= ptr_reg;
            ep_tx_data_reg <= fifo_rd_data;
         end
         // DONE lands one cycle after the final EP write strobe.
         last_reg <= last_pop;
         if (last_reg || start_empty) begin
            done_reg <= 1'b1;
         end else if (status_wr && wb_wdata[STAT_DONE_BIT]) begin
            done_reg <= 1'b0;
         end
         if (push && fifo_full && !pop) begin
            ovf_reg <= 1'b1;
         end else if (status_wr && wb_wdata[STAT_OVF_BIT]) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   assign wb_ack     = wb_ack_reg;
   assign wb_rdata   = wb_rdata_reg;
   assign ep_tx_addr = ep_tx_addr_reg;
   assign ep_tx_data = ep_tx_data_reg;
   assign ep_tx_we   = ep_tx_we_reg;
   assign irq        = done_reg & irq_en_reg;
endmodule

// File: doc/wb_ep_txfifo.md
# wb_ep_txfifo

Wishbone slave on the fabric-side `clk_wb` domain that stages 32-bit words written by the M4 into a small FIFO. On command it copies a programmed number of them into the USB core's endpoint TX buffer through the `ep_tx_*` write port. It sits between the EOS S3 Wishbone interface and the `usb` EP buffer, next to the bridge. It offloads per-word address generation from firmware and provides a completion interrupt.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in 32-bit words; power of two, 4..64.
- `LW`, 5: level/length width, equal to log2(DEPTH)+1.

Ports:
- `clk`  in  1  fabric Wishbone clock (`clk_wb`).
- `rst`  in  1  reset, synchronous, active-high.
- `wb_addr`  in  2  word register index.
- `wb_wdata`  in  32  write data.
- `wb_rdata`  out  32  read data.
- `wb_we`  in  1  write enable.
- `wb_cyc`  in  1  cycle.
- `wb_stb`  in  1  strobe.
- `wb_ack`  out  1  acknowledge.
- `ep_tx_addr`  out  9  EP buffer word address.
- `ep_tx_data`  out  32  EP buffer write data.
- `ep_tx_we`  out  1  EP buffer write strobe.
- `irq`  out  1  completion interrupt, level.

## Operation
Registers:
- 0 DATA (W): push `wb_wdata`. A push when full and not popping in the same cycle is dropped and sets OVF. Reads return 0.
- 1 CTRL (W): [8:0] BASE, [LW+15:16] LEN, [30] IRQ_EN, [31] START (self-clearing). Reads return BASE, LEN and IRQ_EN.
- 2 STATUS (R): [LW-1:0] LEVEL, [8] BUSY, [9] DONE, [10] OVF. Writing 1 to bit 9 or bit 10 clears it.
- 3: reads 0; writes are ignored.

FSM states: IDLE, COPY.
- IDLE -> COPY: CTRL write with START=1 and LEN≠0. Loads ptr←BASE and remaining←LEN.
- CTRL write with START=1 and LEN=0: sets DONE immediately and stays in IDLE.
- START while in COPY: ignored. BASE, LEN and IRQ_EN are still updated for the next run.
- In COPY, each cycle with the FIFO non-empty:
  - pop one word;
  - register `ep_tx_data`←word, `ep_tx_addr`←ptr, `ep_tx_we`←1;
  - ptr←ptr+1 modulo 512, so 511 wraps to 0;
  - remaining−1.
- In COPY with the FIFO empty: stall, `ep_tx_we`=0, BUSY held.
- When the pop that makes remaining 0 occurs: go to IDLE and set DONE.
- `irq` = DONE & IRQ_EN.

FIFO behaviour:
- Push and pop in the same cycle leave LEVEL unchanged. This is allowed at full and at empty+push? No: a pop requires a non-empty FIFO at the start of the cycle.
- Push while full plus pop in the same cycle is accepted.

## Timing
Reset values:
- `wb_ack`=0, `wb_rdata`=0.
- `ep_tx_we`=0, `ep_tx_addr`=0, `ep_tx_data`=0.
- `irq`=0.
- FIFO empty, state IDLE, all CTRL/STATUS fields 0.

Wishbone handshake:
- Request = `wb_cyc & wb_stb & ~wb_ack`.
- `wb_ack` is a single-cycle registered pulse in the next cycle, so there is 1 wait state and back-to-back requests get an ack every other cycle.
- Write side effects (push, START, clears) take place at the same edge that raises `wb_ack`.
- `wb_rdata` is registered and valid while `wb_ack`=1; it is 0 otherwise.

Copy timing:
- The FSM is in COPY from the ack edge. The first `ep_tx_we` pulse appears one cycle after the ack cycle when the FIFO is non-empty.
- Throughput is 1 word per clock when no stall occurs.
- DONE and `irq` are visible in the cycle after the last `ep_tx_we`.

Clear collision: a DONE set and a W1C clear in the same cycle resolve as set wins. The same rule applies to OVF.

Reset mid-COPY: takes effect at the next edge. No further `ep_tx_we` is issued, FIFO contents are discarded, and BUSY is cleared.

## Structure
- Package `wb_ep_txfifo_pkg`: register index constants (REG_DATA=0, REG_CTRL=1, REG_STATUS=2) and bit positions of START, IRQ_EN, BUSY, DONE and OVF.
- Sub-module `fifo_sync`: single-clock FIFO with width/depth parameters, `wr_ena`, `rd_ena`, `full`, `empty`, `level` and show-ahead read data.
- The top level holds the Wishbone decode, the FSM and the output registers.

## Test plan
- Reset, then read STATUS → 0. Push 3 words A,B,C; STATUS LEVEL=3; CTRL BASE=0x010, LEN=3, START → `ep_tx_we` on 3 consecutive cycles at addresses 0x010, 0x011, 0x012 with data A, B, C; then DONE=1 and LEVEL=0.
- BASE=0x1FE, LEN=4 with 4 words → addresses 0x1FE, 0x1FF, 0x000, 0x001.
- LEN=4 with 1 word pushed → one write, then a stall with BUSY=1; push 3 more → remaining 3 writes, then DONE.
- Push 17 words into DEPTH=16 → LEVEL=16 and OVF=1. Write 1 to bit 10 → OVF=0.
- IRQ_EN=1 with LEN=0 START → `irq`=1 after the ack. Write 1 to DONE → `irq`=0. START during COPY → ignored, and the copy count is unchanged.
- Assert `rst` halfway through a LEN=8 copy → no `ep_tx_we` after the reset edge, and STATUS reads 0.
